// File: rtl/ssp_byte_link_if.sv
// ssp_byte_link_if: fabric-side byte stream bundle for ssp_byte_link.
//   tx_data  [7:0]  byte to send
//   tx_valid        push request
//   tx_ready        high while the transmit FIFO is not full
//   rx_data  [7:0]  last complete received byte
//   rx_valid        one-cycle strobe for a new rx_data
// master = fabric (mode/demod logic), slave = the link.
interface ssp_byte_link_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/ssp_byte_link.sv
// ssp_byte_link: byte-oriented SSP link to the ARM SSP peripheral.
// Bytes pushed into a small transmit FIFO are serialised MSB-first on ssp_din
// with a generated ssp_clk and a one-bit-period ssp_frame pulse. ssp_dout is
// deserialised into receive bytes while a word is shifting.
// Ports:
//   ck_1356meg  13.56 MHz clock (only clock)
//   nrst        asynchronous active-low reset
//   enable      link enable; low holds all SSP outputs at 0
//   link        fabric byte stream (ssp_byte_link_if.slave)
//   ssp_clk     SSP bit clock to the ARM
//   ssp_frame   frame sync, high during the first bit of each word
//   ssp_din     serial data to the ARM
//   ssp_dout    serial data from the ARM
// Parameters: DIV (ck cycles per ssp_clk half-period, 1..255),
//             FIFO_DEPTH (power of two, >= 2).
// Build option: define SSP_RX_EN to compile in the receive path; otherwise
// rx_data/rx_valid are tied low and ssp_dout is ignored.
module ssp_byte_link #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           ck_1356meg,
  input  logic           nrst,
  input  logic           enable,
  ssp_byte_link_if.slave link,
  output logic           ssp_clk,
  output logic           ssp_frame,
  output logic           ssp_din,
  input  logic           ssp_dout
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_SHIFT} state_t;

  state_t      state, state_d;
  logic [7:0]  cnt;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  head;
  logic [6:0]  shifter;
  logic [2:0]  idx;
  logic        wrap, fall, rise, empty, full, push, pop;

  assign wrap  = enable && (cnt == DIV_LAST);
  assign fall  = wrap & ssp_clk;
  assign rise  = wrap & ~ssp_clk;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign link.tx_ready = ~full;
  assign push          = link.tx_valid & ~full;

  // empty is taken from the pointers before this cycle's push, so a byte
  // pushed on a fall-event cycle waits for the following fall event.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state)
        ST_OFF:  state_d = ST_IDLE;
        ST_IDLE: begin
          if (fall && !empty) begin
            pop     = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (fall && idx == 3'd0) begin
            if (!empty) pop = 1'b1;
            else        state_d = ST_IDLE;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) state <= ST_OFF;
    else       state <= state_d;
  end

  always_ff @(posedge ck_1356meg) begin
    if (push) mem[wr_ptr[AW-1:0]] <= link.tx_data;
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      ssp_clk   <= 1'b0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
      shifter   <= '0;
      idx       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (!enable) begin
        cnt       <= '0;
        ssp_clk   <= 1'b0;
        ssp_din   <= 1'b0;
        ssp_frame <= 1'b0;
        idx       <= '0;
      end else begin
        cnt <= wrap ? '0 : cnt + 8'd1;
        if (wrap) ssp_clk <= ~ssp_clk;
        // Bit 7 goes straight to ssp_din on load; only bits 6..0 are kept.
        if (pop) begin
          shifter   <= head[6:0];
          idx       <= 3'd7;
          ssp_din   <= head[7];
          ssp_frame <= 1'b1;
        end else if (fall && state == ST_SHIFT) begin
          ssp_frame <= 1'b0;
          if (idx != 3'd0) begin
            idx     <= idx - 3'd1;
            ssp_din <= shifter[idx - 3'd1];
          end else begin
            ssp_din <= 1'b0;
          end
        end
      end
    end
  end

`ifdef SSP_RX_EN
  logic [6:0] rx_sh;

  // rise already requires enable, so an aborted word never strobes rx_valid.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      rx_sh         <= '0;
      link.rx_data  <= '0;
      link.rx_valid <= 1'b0;
    end else begin
      link.rx_valid <= 1'b0;
      if (state == ST_SHIFT && rise) begin
        rx_sh <= {rx_sh[5:0], ssp_dout};
        if (idx == 3'd0) begin
          link.rx_data  <= {rx_sh, ssp_dout};
          link.rx_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_dout;
  assign unused_dout   = ssp_dout;
  assign link.rx_data  = '0;
  assign link.rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_byte_link.sv
module tb_ssp_byte_link;
  localparam int DIV = 4;
`ifdef SSP_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst, enable, ssp_clk, ssp_frame, ssp_din, ssp_dout;
  int   checks = 0;
  int   errors = 0;

  ssp_byte_link_if link();

  ssp_byte_link #(.DIV(DIV), .FIFO_DEPTH(4)) dut (
    .ck_1356meg(clk),
    .nrst      (nrst),
    .enable    (enable),
    .link      (link),
    .ssp_clk   (ssp_clk),
    .ssp_frame (ssp_frame),
    .ssp_din   (ssp_din),
    .ssp_dout  (ssp_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] tx;
    logic [7:0] bits;   // expected ssp_din sequence, first bit in [7]
    logic [7:0] dout;   // byte the ARM drives on ssp_dout
    logic [7:0] rx;     // expected rx_data with the receive path present
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    link.tx_data  = b;
    link.tx_valid = 1'b1;
    @(negedge clk);
    link.tx_valid = 1'b0;
  endtask

  // Checks one full word cycle by cycle. Sample c=0 is the first negedge
  // after the fall event that loads the word.
  task automatic check_word(input string nm, input logic [7:0] bits, input logic [7:0] dout,
                            input logic [7:0] exprx, input bit contig, output int lat);
    int bd = 0, bf = 0, bc = 0, bv = 0;
    logic [7:0] rxd = 8'h00;
    lat = 0;
    @(negedge clk);
    if (contig) begin
      chk({nm, " contiguous frame"}, 32'(ssp_frame), 32'd1);
    end else begin
      while (!ssp_frame && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      if (!ssp_frame) begin
        checks++;
        errors++;
        $display("FAIL %s start: no ssp_frame within %0d cycles", nm, lat);
        return;
      end
    end
    for (int c = 0; c < 16*DIV; c++) begin
      int b;
      if (c > 0) @(negedge clk);
      b = 7 - c / (2*DIV);
      if (ssp_din !== bits[b]) bd++;
      if (ssp_frame !== (c < 2*DIV)) bf++;
      if (ssp_clk !== ((c % (2*DIV)) >= DIV)) bc++;
      if (link.rx_valid !== (RX_ON && c == 16*DIV - DIV)) bv++;
      if (c == 16*DIV - DIV) rxd = link.rx_data;
      if (c % (2*DIV) == 0) ssp_dout = dout[b];
    end
    chk({nm, " din bad cycles"},      32'(bd), 32'd0);
    chk({nm, " frame bad cycles"},    32'(bf), 32'd0);
    chk({nm, " ssp_clk bad cycles"},  32'(bc), 32'd0);
    chk({nm, " rx_valid bad cycles"}, 32'(bv), 32'd0);
    chk({nm, " rx_data"},             32'(rxd), 32'(exprx));
  endtask

  task automatic idle_after(input string nm);
    @(negedge clk);
    chk({nm, " idle din"},   32'(ssp_din),   32'd0);
    chk({nm, " idle frame"}, 32'(ssp_frame), 32'd0);
  endtask

  task automatic watch_quiet(input string nm, input int n);
    int fr = 0, rv = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ssp_frame) fr++;
      if (link.rx_valid) rv++;
    end
    chk({nm, " frame cycles"},    32'(fr), 32'd0);
    chk({nm, " rx_valid cycles"}, 32'(rv), 32'd0);
  endtask

  task automatic wait_frame(input string nm, output bit ok);
    int n = 0;
    while (!ssp_frame && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = ssp_frame;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no ssp_frame within %0d cycles", nm, n);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " tx_ready"},  32'(link.tx_ready), 32'd1);
    chk({nm, " rx_data"},   32'(link.rx_data),  32'h00);
    chk({nm, " rx_valid"},  32'(link.rx_valid), 32'd0);
    chk({nm, " ssp_clk"},   32'(ssp_clk),       32'd0);
    chk({nm, " ssp_frame"}, 32'(ssp_frame),     32'd0);
    chk({nm, " ssp_din"},   32'(ssp_din),       32'd0);
  endtask

  initial begin
    int lat;
    bit ok;
    int rv;
    logic [7:0] fill [5];

    vecs[0] = '{8'hA5, 8'b1010_0101, 8'h3C, 8'h3C};
    vecs[1] = '{8'h80, 8'b1000_0000, 8'h81, 8'h81};
    vecs[2] = '{8'h01, 8'b0000_0001, 8'hFF, 8'hFF};
    vecs[3] = '{8'h7E, 8'b0111_1110, 8'h00, 8'h00};
    vecs[4] = '{8'hFF, 8'b1111_1111, 8'h5B, 8'h5B};

    nrst = 1'b0;
    enable = 1'b0;
    link.tx_valid = 1'b0;
    link.tx_data = 8'h00;
    ssp_dout = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Single words from IDLE, with latency bound and idle afterwards.
    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      push(vecs[i].tx);
      check_word(nm, vecs[i].bits, vecs[i].dout, RX_ON ? vecs[i].rx : 8'h00, 1'b0, lat);
      checks++;
      if (lat > 2*DIV - 1) begin
        errors++;
        $display("FAIL %s latency: got %0d extra cycles, want <= %0d", nm, lat, 2*DIV - 1);
      end
      idle_after(nm);
    end

    // Back-to-back words.
    push(8'h12);
    push(8'h34);
    check_word("b2b_12", 8'b0001_0010, 8'hC3, RX_ON ? 8'hC3 : 8'h00, 1'b0, lat);
    check_word("b2b_34", 8'b0011_0100, 8'h5A, RX_ON ? 8'h5A : 8'h00, 1'b1, lat);
    idle_after("b2b");

    // FIFO full while disabled.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("off ssp_clk",   32'(ssp_clk),   32'd0);
    chk("off ssp_din",   32'(ssp_din),   32'd0);
    chk("off ssp_frame", 32'(ssp_frame), 32'd0);
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full tx_ready before push %0d", i), 32'(link.tx_ready), (i < 4) ? 32'd1 : 32'd0);
      link.tx_data  = fill[i];
      link.tx_valid = 1'b1;
      @(negedge clk);
    end
    link.tx_valid = 1'b0;
    chk("full tx_ready after pushes", 32'(link.tx_ready), 32'd0);
    enable = 1'b1;
    check_word("full_11", 8'b0001_0001, 8'h01, RX_ON ? 8'h01 : 8'h00, 1'b0, lat);
    check_word("full_22", 8'b0010_0010, 8'h02, RX_ON ? 8'h02 : 8'h00, 1'b1, lat);
    check_word("full_33", 8'b0011_0011, 8'h04, RX_ON ? 8'h04 : 8'h00, 1'b1, lat);
    check_word("full_44", 8'b0100_0100, 8'h08, RX_ON ? 8'h08 : 8'h00, 1'b1, lat);
    idle_after("full");
    watch_quiet("full no 5th word", 100);

    // Abort during bit 4 of the first of two queued words.
    push(8'hC3);
    push(8'h5A);
    wait_frame("abort start", ok);
    if (ok) begin
      rv = 0;
      for (int c = 0; c <= 26; c++) begin
        if (c > 0) @(negedge clk);
        if (link.rx_valid) rv++;
        ssp_dout = 1'b1;
      end
      enable = 1'b0;
      @(negedge clk);
      if (link.rx_valid) rv++;
      chk("abort ssp_clk",   32'(ssp_clk),   32'd0);
      chk("abort ssp_din",   32'(ssp_din),   32'd0);
      chk("abort ssp_frame", 32'(ssp_frame), 32'd0);
      chk("abort rx_valid during word", 32'(rv), 32'd0);
      watch_quiet("abort off", 40);
      enable = 1'b1;
      check_word("abort_5A", 8'b0101_1010, 8'h96, RX_ON ? 8'h96 : 8'h00, 1'b0, lat);
      idle_after("abort");
    end

    // Reset in the middle of a word with a second word queued.
    push(8'hAA);
    push(8'hBB);
    wait_frame("midreset start", ok);
    if (ok) begin
      repeat (20) @(negedge clk);
      nrst = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(negedge clk);
      nrst = 1'b1;
      watch_quiet("midreset no stale word", 150);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ssp_byte_link.md
# ssp_byte_link

Byte-oriented SSP link between the FPGA fabric and the ARM's SSP peripheral. Demodulator and mode logic push 8-bit words into a small transmit FIFO. The block serialises them MSB-first onto `ssp_din` with a generated `ssp_clk` and a one-bit `ssp_frame` pulse. At the same time it deserialises `ssp_dout` from the ARM into receive bytes. It replaces the ad-hoc counter-based SSP generation in the top level and sits between the high-frequency mode modules and the SSP pins.

## Interface

Parameters:
- `DIV`, default 4: `ck_1356meg` cycles per `ssp_clk` half-period. Range is 1..255. With the default, `ssp_clk` = 13.56 MHz / 8.
- `FIFO_DEPTH`, default 4: transmit FIFO entries. Must be a power of two, at least 2.

Ports:
- `ck_1356meg` in 1: the only clock, 13.56 MHz.
- `nrst` in 1: asynchronous active-low reset.
- `enable` in 1: link enable. When low, the link is held quiet.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: push request.
- `tx_ready` out 1: high while the FIFO is not full.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: one-cycle strobe that a new `rx_data` is available.
- `ssp_clk` out 1: SSP bit clock to the ARM.
- `ssp_frame` out 1: frame sync to the ARM.
- `ssp_din` out 1: serial data to the ARM.
- `ssp_dout` in 1: serial data from the ARM.

## Operation

- **Push rule:** a push occurs on a cycle with `tx_valid & tx_ready`. A push while full is impossible by definition and is ignored. `tx_ready` reflects full-ness before any same-cycle pop.
- **Prescaler:**
  - While `enable` is high, the prescaler counts 0..DIV-1. `ssp_clk` toggles on the cycle the count wraps.
  - The 1→0 toggle is a "fall event"; the 0→1 toggle is a "rise event".
  - While `enable` is low: prescaler = 0, `ssp_clk` = 0.
- **States:**
  - OFF (`enable` low): all SSP outputs 0. FIFO contents are retained and pushes are still accepted.
  - IDLE: `ssp_clk` runs; `ssp_frame` = 0, `ssp_din` = 0. At each fall event, if the FIFO is non-empty: pop, load the shifter, bit index = 7, go to SHIFT.
  - SHIFT: `ssp_din` = shifter bit[index]. `ssp_frame` = 1 only while index = 7. At each fall event, index decrements.
    - After the index-0 bit period, pop and reload if the FIFO is non-empty (back-to-back, no gap); otherwise go to IDLE.
- **Output update:** `ssp_din` and `ssp_frame` change on the same clock edge as the fall event, so the ARM samples them on the rising edge.
- **Receive path:**
  - In SHIFT, at each rise event, `ssp_dout` is shifted into the receive register MSB-first.
  - On the 8th sample (index 0), `rx_data` loads the byte and `rx_valid` = 1 for exactly one cycle.
  - There is no backpressure; a byte not consumed is overwritten by the next one.
- **Enable falling mid-word:** the word is aborted, the popped byte is lost, no `rx_valid` is produced, and the block goes to OFF on the next cycle. The next enable starts from the next FIFO entry.
- **Empty FIFO with a same-cycle push at a fall event:** the new entry is not visible to the pop. It starts at the following fall event.
- **FIFO pointers:** log2(FIFO_DEPTH)+1 bits, wrapping modulo 2·FIFO_DEPTH. Full when MSBs differ and the low bits are equal.

## Timing

- **Reset values:** `tx_ready` = 1, `rx_data` = 8'h00, `rx_valid` = 0, `ssp_clk` = 0, `ssp_frame` = 0, `ssp_din` = 0. FIFO empty, state OFF or IDLE per `enable`.
- **Reset mid-word:** asynchronous clear to the values above; the FIFO is emptied.
- **Clock timing:**
  - First rise event: DIV cycles after `enable` is sampled high.
  - First fall event: 2·DIV cycles after `enable` is sampled high.
  - Bit period = 2·DIV cycles; word = 16·DIV cycles (64 at the default DIV).
- **Transmit latency:** a push into an empty FIFO with the link in IDLE appears on `ssp_din` at the next fall event, at most 2·DIV cycles later.
- **Receive latency:** `rx_valid` asserts on the clock edge of the 8th rise event, i.e. DIV cycles before the word's final fall event.

## Configuration

- `SSP_RX_EN` defined: the receive path is compiled in as described above.
- `SSP_RX_EN` undefined:
  - The receive shifter is removed and `ssp_dout` is ignored.
  - `rx_data` is tied to 8'h00 and `rx_valid` to 0.
  - Transmit behaviour is identical.

## Test plan

- **Reset:** assert `nrst` low mid-word → all outputs at reset values immediately; `tx_ready` = 1; after release, no stale word is transmitted.
- **Single byte:** DIV = 4, enable, push 8'hA5 → `ssp_din` = 1,0,1,0,0,1,0,1, each held 8 cycles; `ssp_frame` high for exactly the first 8 cycles; `ssp_clk` period 8 cycles; then IDLE with `ssp_din` = 0.
- **Back-to-back:** push 8'h12 then 8'h34 → two contiguous 64-cycle words with no idle bit between them, and `ssp_frame` pulsed at the start of each.
- **FIFO full:** `enable` low, push 5 bytes → `tx_ready` falls after the 4th push and the 5th is ignored; raise `enable` → exactly the 4 words are sent, in order.
- **Receive (`SSP_RX_EN` defined):** drive `ssp_dout` = 8'h3C MSB-first, changing on `ssp_clk` falls during a word → `rx_data` = 8'h3C with a single-cycle `rx_valid` at the 8th rise.
- **Abort:** drop `enable` during bit 4 of the first of two queued words → outputs 0 on the next cycle, no `rx_valid`; re-enable → the second word is sent intact.
